// File: rtl/adder_pkg.sv
// Shared definitions for the adder test family.
// FSM states, mode encodings and the operand-width legality check.
package adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit combinational full-adder cell.
// The single arithmetic element shared by every bit of a serial operation.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of three single-bit inputs
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Subtraction is a + ~b + 1 with the +1 injected through the carry flop.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("serial_adder: WIDTH out of range 2..64");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic fa_sum;
    logic fa_cout;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state: latch operands on start, then shift one bit per cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (sub == MODE_SUB) ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                r_d = {fa_sum, r_q[WIDTH-1:1]};
                c_d = fa_cout;
                if (cnt_q == LAST) begin
                    sum_d   = r_d;
                    cout_d  = fa_cout;
                    ovf_d   = c_q ^ fa_cout;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = done_q;
        sum       = sum_q;
        carry_out = cout_q;
        overflow  = ovf_q;
    end

endmodule
